mac_layer: RTL and testbench

MAC_LAYER -- requirements
Module: mac_layer

---
 rtl/mac_layer.sv | 60 ++++++
 tb/tb_mac_layer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_layer.sv
// mac_layer: NEURON_NB parallel signed fixed-point MACs with bias preload, floor shift and saturating output
module mac_layer #(
  parameter int NEURON_NB = 10,
  parameter int IN_SIZE   = 196,
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mac_go,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [WIDTH*NEURON_NB-1:0] weight_array,
  input  logic [WIDTH*NEURON_NB-1:0] bias_array,
  output logic [WIDTH*NEURON_NB-1:0] data_out_array,
  output logic                       mac_layer_done
);
  localparam int ACC_W = 2*WIDTH + $clog2(IN_SIZE) + 1;
  localparam int CW = IN_SIZE > 1 ? $clog2(IN_SIZE) : 1;
  localparam logic signed [ACC_W-1:0] MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACCUM, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic start, take, last;
  logic [WIDTH*NEURON_NB-1:0] sat;
  assign start = (state == IDLE || state == DONE) && mac_go;
  assign take = state == ACCUM && in_valid;
  assign last = take && cnt == CW'(IN_SIZE-1);
  always_comb begin
    in_ready = state == ACCUM;
    mac_layer_done = state == DONE;
    nxt = start ? ACCUM : state == ACCUM ? (last ? WRITE : ACCUM) : state == WRITE ? DONE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (start) cnt <= '0;
    else if (take) cnt <= last ? '0 : cnt + CW'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) data_out_array <= '0;
    else if (state == WRITE) data_out_array <= sat;
  for (genvar i = 0; i < NEURON_NB; i++) begin : g_n
    logic [WIDTH-1:0] w, b;
    logic [2*WIDTH-1:0] p;
    logic signed [ACC_W-1:0] acc, sh;
    assign w = weight_array[i*WIDTH +: WIDTH];
    assign b = bias_array[i*WIDTH +: WIDTH];
    assign p = {{WIDTH{data_in[WIDTH-1]}}, data_in} * {{WIDTH{w[WIDTH-1]}}, w};
    assign sh = acc >>> FRAC_BITS;
    assign sat[i*WIDTH +: WIDTH] = sh > MAX ? MAX[WIDTH-1:0] : sh < MIN ? MIN[WIDTH-1:0] : sh[WIDTH-1:0];
    always_ff @(posedge clk or posedge reset)
      if (reset) acc <= '0;
      else if (start) acc <= {{(ACC_W-WIDTH){b[WIDTH-1]}}, b} <<< FRAC_BITS;
      else if (take) acc <= acc + {{(ACC_W-2*WIDTH){p[2*WIDTH-1]}}, p};
  end
endmodule

// File: tb/tb_mac_layer.sv
// tb_mac_layer: table-driven scoreboard bench for mac_layer (2 neurons, 3 elements, Q16.16)
module tb_mac_layer;
  localparam int N = 2;
  localparam int IS = 3;
  localparam int W = 32;
  logic clk = 0;
  logic reset = 0;
  logic mac_go = 0;
  logic in_valid = 0;
  logic in_ready, mac_layer_done;
  logic [W-1:0] data_in = '0;
  logic [W*N-1:0] weight_array = '0;
  logic [W*N-1:0] bias_array = '0;
  logic [W*N-1:0] data_out_array;
  int tests = 0;
  int fails = 0;
  logic [63:0] prev_out = '0;
  typedef struct {
    logic [2:0][31:0] d, w0, w1;
    logic [31:0] b0, b1, e0, e1;
    bit stall, hold;
  } vec_t;
  typedef struct {
    logic [63:0] out;
    int lat;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[8];
  mac_layer #(.NEURON_NB(N), .IN_SIZE(IS), .WIDTH(W), .FRAC_BITS(16)) dut (
    .clk(clk),
    .reset(reset),
    .mac_go(mac_go),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .weight_array(weight_array),
    .bias_array(bias_array),
    .data_out_array(data_out_array),
    .mac_layer_done(mac_layer_done)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [31:0] d0, d1, d2, a0, a1, a2, c0, c1, c2, b0, b1, e0, e1,
                              input bit stall, input bit hold);
    vec_t v;
    v.d = {d2, d1, d0};
    v.w0 = {a2, a1, a0};
    v.w1 = {c2, c1, c0};
    v.b0 = b0;
    v.b1 = b1;
    v.e0 = e0;
    v.e1 = e1;
    v.stall = stall;
    v.hold = hold;
    return v;
  endfunction
  function automatic logic [31:0] model(input logic [95:0] d, input logic [95:0] w, input logic [31:0] b);
    logic signed [127:0] a;
    longint pr, s;
    a = {{96{b[31]}}, b};
    a = a <<< 16;
    for (int k = 0; k < IS; k++) begin
      pr = longint'($signed(d[k*32 +: 32])) * longint'($signed(w[k*32 +: 32]));
      a = a + {{64{pr[63]}}, pr};
    end
    a = a >>> 16;
    s = a[63:0];
    return s > 64'sh7FFFFFFF ? 32'h7FFFFFFF : s < -64'sh80000000 ? 32'h80000000 : s[31:0];
  endfunction
  task automatic run(input vec_t v, input bit now);
    int cyc, idx, p;
    bit dn, hold_ok, rdy_done;
    logic [5:0] pat;
    exp_t e;
    pat = v.stall ? 6'b101001 : 6'b111111;
    sb.push_back('{out: {v.e1, v.e0}, lat: v.stall ? 8 : 5});
    if (!now) @(negedge clk);
    bias_array = {v.b1, v.b0};
    mac_go = 1;
    in_valid = 1;
    data_in = $urandom;
    weight_array = {$urandom, $urandom};
    cyc = 0;
    idx = 0;
    p = 0;
    dn = 0;
    hold_ok = 1;
    rdy_done = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      mac_go = v.hold && cyc == 1;
      bias_array = {$urandom, $urandom};
      if (cyc == 1) check("done_low_after_go", 64'(mac_layer_done), 64'd0);
      if (mac_layer_done) begin
        dn = 1;
        break;
      end
      if (data_out_array !== prev_out) hold_ok = 0;
      if (idx == IS && !rdy_done) begin
        check("in_ready_low_after_last", 64'(in_ready), 64'd0);
        rdy_done = 1;
      end
      if (in_ready && idx < IS) begin
        in_valid = pat[p];
        p++;
        data_in = in_valid ? v.d[idx] : $urandom;
        weight_array = in_valid ? {v.w1[idx], v.w0[idx]} : {$urandom, $urandom};
        if (in_valid) idx++;
      end else begin
        in_valid = 1'($urandom);
        data_in = $urandom;
        weight_array = {$urandom, $urandom};
      end
    end
    in_valid = 0;
    e = sb.pop_front();
    check("done_latency", 64'(dn ? cyc : -1), 64'(e.lat));
    check("out_hold_until_write", 64'(hold_ok), 64'd1);
    check("out0", 64'(data_out_array[31:0]), 64'(e.out[31:0]));
    check("out1", 64'(data_out_array[63:32]), 64'(e.out[63:32]));
    prev_out = e.out;
  endtask
  initial begin
    vec_t v;
    int dcnt;
    tbl[0] = mk(32'h10000, 32'h10000, 32'h10000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000,
                32'h0, 32'h0, 32'h18000, 32'h18000, 0, 0);
    tbl[1] = mk(32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'h10000,
                32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'h10000, 32'hFFFF0000, 32'h40000, 32'hFFFC0000, 0, 0);
    tbl[2] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0);
    tbl[3] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000001, 32'h80000001, 32'h80000001,
                32'h80000001, 32'h80000001, 32'h80000001, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 0, 0);
    tbl[4] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h8000, 32'h8000, 32'h8000, 32'h1, 32'h1, 32'h1,
                32'h0, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0);
    tbl[5] = mk(32'h20000, 32'hFFFF0000, 32'h8000, 32'h10000, 32'h20000, 32'h40000, 32'hFFFF8000, 32'h10000, 32'h0,
                32'h8000, 32'h30000, 32'h28000, 32'h10000, 0, 0);
    tbl[6] = mk(32'h10000, 32'h10000, 32'h10000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000, 32'h8000,
                32'h0, 32'h0, 32'h18000, 32'h18000, 1, 0);
    tbl[7] = tbl[1];
    tbl[7].hold = 1;
    #1 reset = 1;
    #1;
    check("reset_out", data_out_array, 64'd0);
    check("reset_done", 64'(mac_layer_done), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 8; i++) run(tbl[i], i == 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < IS; k++) begin
        v.d[k] = r < 2 ? $urandom_range(0, 32'h3FFFF) - 32'h20000 : $urandom;
        v.w0[k] = r < 2 ? $urandom_range(0, 32'h3FFFF) - 32'h20000 : $urandom;
        v.w1[k] = r < 2 ? $urandom_range(0, 32'h3FFFF) - 32'h20000 : $urandom;
      end
      v.b0 = $urandom_range(0, 32'h3FFFF) - 32'h20000;
      v.b1 = r < 2 ? $urandom_range(0, 32'h3FFFF) - 32'h20000 : $urandom;
      v.e0 = model(v.d, v.w0, v.b0);
      v.e1 = model(v.d, v.w1, v.b1);
      v.stall = r[0];
      v.hold = 0;
      run(v, 0);
    end
    run(tbl[5], 0);
    @(negedge clk);
    bias_array = '0;
    mac_go = 1;
    @(negedge clk);
    mac_go = 0;
    in_valid = 1;
    data_in = 32'h10000;
    weight_array = {2{32'h8000}};
    repeat (2) @(negedge clk);
    in_valid = 0;
    reset = 1;
    #1;
    check("midop_reset_out", data_out_array, 64'd0);
    check("midop_reset_done", 64'(mac_layer_done), 64'd0);
    check("midop_reset_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    reset = 0;
    prev_out = '0;
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (mac_layer_done) dcnt++;
    end
    check("no_done_after_reset", 64'(dcnt), 64'd0);
    check("out_zero_after_reset", data_out_array, 64'd0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    run(tbl[0], 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
